demux3_stream: RTL and testbench
================================

DEMUX3_STREAM -- requirements
Module: demux3_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width of the input and each output.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, a synchronous active-high reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits, the item to be routed.
REQ-005 The block SHALL have port in_sel, input, 2 bits, the destination select, decoded as 00 -> out0, 01 -> out1, 10 or 11 -> out2.
REQ-006 The block SHALL have port in_valid, input, 1 bit, which the producer asserts while in_data and in_sel are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit, which the block asserts when the selected destination can accept an item this cycle.
REQ-008 The block SHALL have ports out_data0, out_data1 and out_data2, outputs, WIDTH bits each, the held item per destination.
REQ-009 The block SHALL have port out_valid, output, 3 bits, where bit k means out_datak holds an item.
REQ-010 The block SHALL have port out_ready, input, 3 bits, where bit k means consumer k accepts the item this cycle.
REQ-011 The block SHALL have ports cnt0, cnt1 and cnt2, outputs, 8 bits each, the per-destination accepted-item counters (see Configuration).

Function
REQ-012 Each destination k SHALL own a one-entry holding register (data plus a valid bit) driving out_datak and out_valid[k].
REQ-013 A transfer on the input SHALL occur in a cycle where in_valid=1 and in_ready=1; a transfer on destination k SHALL occur in a cycle where out_valid[k]=1 and out_ready[k]=1.
REQ-014 in_ready SHALL equal (~out_valid[t] | out_ready[t]), where t is the destination decoded from the current in_sel; this is a combinational path from in_sel and out_ready to in_ready.
REQ-015 On an input transfer, slot t SHALL capture in_data at the clock edge, and out_valid[t] SHALL be 1 on the following cycle (latency 1 cycle).
REQ-016 On an output transfer without a refill of the same slot, out_valid[k] SHALL be 0 on the following cycle.
REQ-017 Simultaneous drain and refill of slot k in the same cycle SHALL leave out_valid[k]=1 with the new data, with no bubble.
REQ-018 Slots not targeted by the current transfer SHALL hold their data and valid bit unchanged, except when drained.
REQ-019 While a slot is valid, out_datak SHALL be stable until it is drained.
REQ-020 A full target with out_ready[t]=0 SHALL stall the input (head-of-line), regardless of the state of the other slots.
REQ-021 in_sel and in_data SHALL be ignored when in_valid=0; no state SHALL change from them in that case.
REQ-022 All three slots SHALL be able to drain in the same cycle.

Reset
REQ-023 When reset=1 at a clock edge, out_valid SHALL become 000, out_data0/1/2 SHALL become 0, and cnt0/1/2 SHALL become 0.
REQ-024 reset SHALL take priority over any simultaneous input or output transfer; items held or being accepted at that edge SHALL be discarded.
REQ-025 in_ready SHALL evaluate to 1 during the cycle after reset, since all slots are empty.

Configuration
REQ-026 With macro DEMUX3_STREAM_CNT_EN defined, cntk SHALL increment by 1 on each input transfer routed to destination k and SHALL wrap from 255 to 0.
REQ-027 Without DEMUX3_STREAM_CNT_EN, no counter state SHALL be built, and cnt0/1/2 SHALL be tied to 0.

Verification
REQ-028 Reset test: after reset, assert in_valid=1, in_sel=01, in_data=8'hA5 with out_ready=000 -> the next cycle shows out_valid=010 and out_data1=A5, and cnt1=1 (with the counter enabled).
REQ-029 Select-decode test: apply in_sel=11 and in_data=8'h3C -> out_valid[2]=1 and out_data2=3C.
REQ-030 Stall test: with slot 0 full and out_ready[0]=0, apply in_sel=00 -> in_ready=0 and the slot contents are unchanged; raise out_ready[0] -> in_ready=1, and the new item replaces the old one with out_valid[0] held at 1.
REQ-031 Streaming test: send 10 items to out2 with out_ready[2]=1 held -> one item per cycle, no bubbles, and the output order matches the input order.
REQ-032 Mid-operation reset test: assert reset while all slots are full and an input transfer is pending -> out_valid=000 and cnt0/1/2=0 on the next cycle.
REQ-033 Counter wrap test: send 256 items to out0 -> cnt0 returns to 0; without the macro, cnt0 stays 0 throughout.

Source files
------------

// File: rtl/demux3_stream.sv
// demux3_stream: a 1-to-3 valid/ready stream demultiplexer.
// Each destination owns a one-entry holding register. in_ready is a
// combinational function of in_sel and the state of the selected slot, so a
// full, non-draining target stalls the input (head-of-line blocking).
// Optional feature: define DEMUX3_STREAM_CNT_EN to build 8-bit wrapping
// per-destination accepted-item counters. Without it, cnt0/1/2 read 0.
module demux3_stream #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data0,
   output logic [WIDTH-1:0] out_data1,
   output logic [WIDTH-1:0] out_data2,
   output logic [2:0]       out_valid,
   input  logic [2:0]       out_ready,
   output logic [7:0]       cnt0,
   output logic [7:0]       cnt1,
   output logic [7:0]       cnt2
);

   logic [2:0]       tgt_s;
   logic [2:0]       load_s;
   logic [2:0]       drain_s;
   logic             in_fire_s;
   logic [2:0]       valid_d;
   logic [2:0]       valid_q;
   logic [WIDTH-1:0] data_d [3];
   logic [WIDTH-1:0] data_q [3];

   // Decode the destination select into a one-hot target (10 and 11 both go to out2)
   always_comb begin
      case (in_sel)
         2'b00:   tgt_s = 3'b001;
         2'b01:   tgt_s = 3'b010;
         default: tgt_s = 3'b100;
      endcase
   end

   // Input may proceed when the selected slot is empty or is being drained this cycle
   always_comb begin
      in_ready = |(tgt_s & (~valid_q | out_ready));
   end

   // Next-state for every slot: drain clears, load sets and captures (load wins, so no bubble)
   always_comb begin
      in_fire_s = in_valid & in_ready;
      if (in_fire_s) begin
         load_s = tgt_s;
      end else begin
         load_s = 3'b000;
      end
      drain_s = valid_q & out_ready;
      valid_d = (valid_q & ~drain_s) | load_s;
      for (int k = 0; k < 3; k++) begin
         if (load_s[k]) begin
            data_d[k] = in_data;
         end else begin
            data_d[k] = data_q[k];
         end
      end
   end

   // Holding registers; reset discards anything held or being accepted
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            data_q[k] <= {WIDTH{1'b0}};
         end
      end else begin
         valid_q <= valid_d;
         for (int k = 0; k < 3; k++) begin
            data_q[k] <= data_d[k];
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data0 = data_q[0];
   assign out_data1 = data_q[1];
   assign out_data2 = data_q[2];

`ifdef DEMUX3_STREAM_CNT_EN
   logic [7:0] cnt_d [3];
   logic [7:0] cnt_q [3];

   // Count accepted items per destination; 8-bit arithmetic wraps 255 -> 0
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         if (load_s[k]) begin
            cnt_d[k] = cnt_q[k] + 8'd1;
         end else begin
            cnt_d[k] = cnt_q[k];
         end
      end
   end

   // Counter registers, cleared by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= 8'd0;
         end
      end else begin
         for (int k = 0; k < 3; k++) begin
            cnt_q[k] <= cnt_d[k];
         end
      end
   end

   assign cnt0 = cnt_q[0];
   assign cnt1 = cnt_q[1];
   assign cnt2 = cnt_q[2];
`else
   assign cnt0 = 8'd0;
   assign cnt1 = 8'd0;
   assign cnt2 = 8'd0;
`endif

endmodule

// File: tb/tb_demux3_stream.sv
// Testbench for demux3_stream: directed scenarios followed by random traffic.
// The reference model is a per-destination queue of at most one item plus a
// modulo-256 accept count per destination; a monitor compares the DUT against
// it once per cycle, just before each rising edge.
module tb_demux3_stream;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data0, out_data1, out_data2;
   logic [2:0] out_valid;
   logic [2:0] out_ready;
   logic [7:0] cnt0, cnt1, cnt2;

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] mq [3][$];
   int         mcnt [3];
   int         drains [3];
   bit         mon_en = 1'b0;

   always #5 clk = ~clk;

   demux3_stream #(.WIDTH(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data0 (out_data0),
      .out_data1 (out_data1),
      .out_data2 (out_data2),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .cnt0      (cnt0),
      .cnt1      (cnt1),
      .cnt2      (cnt2)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input bit r, input bit v, input logic [1:0] s,
                        input logic [7:0] d, input logic [2:0] ordy);
      @(negedge clk);
      reset     = r;
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = ordy;
   endtask

   // Monitor: compare DUT against the queue model 1 time unit before each rising edge
   always begin : monitor
      logic [7:0] od [3];
      logic [7:0] oc [3];
      int         t;
      bit         exp_rdy;
      @(negedge clk);
      #4;
      if (mon_en) begin
         od[0] = out_data0; od[1] = out_data1; od[2] = out_data2;
         oc[0] = cnt0;      oc[1] = cnt1;      oc[2] = cnt2;
         t = (in_sel == 2'b00) ? 0 : ((in_sel == 2'b01) ? 1 : 2);
         exp_rdy = (mq[t].size() == 0) || (out_ready[t] == 1'b1);
         chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("out_valid[%0d]", k), {31'd0, out_valid[k]},
                (mq[k].size() != 0) ? 32'd1 : 32'd0);
            if (mq[k].size() != 0)
               chk($sformatf("out_data%0d", k), {24'd0, od[k]}, {24'd0, mq[k][0]});
`ifdef DEMUX3_STREAM_CNT_EN
            chk($sformatf("cnt%0d", k), {24'd0, oc[k]}, mcnt[k]);
`else
            chk($sformatf("cnt%0d", k), {24'd0, oc[k]}, 32'd0);
`endif
         end
         if (reset) begin
            for (int k = 0; k < 3; k++) begin
               mq[k].delete();
               mcnt[k] = 0;
            end
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (mq[k].size() != 0 && out_ready[k]) begin
                  void'(mq[k].pop_front());
                  drains[k]++;
               end
            end
            if (in_valid && exp_rdy) begin
               mq[t].push_back(in_data);
               mcnt[t] = (mcnt[t] + 1) % 256;
            end
         end
      end
   end

   initial begin
      int d0;
      reset = 1'b1; in_valid = 1'b0; in_sel = 2'b00; in_data = 8'h00; out_ready = 3'b000;
      for (int k = 0; k < 3; k++) begin
         mcnt[k] = 0;
         drains[k] = 0;
      end
      repeat (2) @(negedge clk);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
      mon_en = 1'b1;
      #2;
      chk("rst out_valid", {29'd0, out_valid}, 32'd0);
      chk("rst out_data0", {24'd0, out_data0}, 32'd0);
      chk("rst out_data1", {24'd0, out_data1}, 32'd0);
      chk("rst out_data2", {24'd0, out_data2}, 32'd0);
      chk("rst in_ready", {31'd0, in_ready}, 32'd1);

      // Single item to out1, then select 11 to out2
      drive(1'b0, 1'b1, 2'b01, 8'hA5, 3'b000);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
      #2;
      chk("first out_valid", {29'd0, out_valid}, 32'd2);
      chk("first out_data1", {24'd0, out_data1}, 32'hA5);
      drive(1'b0, 1'b1, 2'b11, 8'h3C, 3'b000);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
      #2;
      chk("sel11 out_data2", {24'd0, out_data2}, 32'h3C);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

      // Head-of-line stall on slot 0, then drain-and-refill in one cycle
      drive(1'b0, 1'b1, 2'b00, 8'h11, 3'b000);
      repeat (3) drive(1'b0, 1'b1, 2'b00, 8'h22, 3'b110);
      drive(1'b0, 1'b1, 2'b00, 8'h22, 3'b001);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
      #2;
      chk("refill out_data0", {24'd0, out_data0}, 32'h22);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);

      // Stream 10 items to out2 with ready held high
      d0 = drains[2];
      for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 2'b10, 8'(8'h40 + i), 3'b100);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b100);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b100);
      chk("stream drains", drains[2] - d0, 32'd10);

      // Reset while all slots are full and a transfer is pending
      drive(1'b0, 1'b1, 2'b00, 8'hD0, 3'b000);
      drive(1'b0, 1'b1, 2'b01, 8'hD1, 3'b000);
      drive(1'b0, 1'b1, 2'b10, 8'hD2, 3'b000);
      drive(1'b1, 1'b1, 2'b00, 8'h77, 3'b001);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b000);
      #2;
      chk("midrst out_valid", {29'd0, out_valid}, 32'd0);
      chk("midrst cnt0", {24'd0, cnt0}, 32'd0);
      chk("midrst cnt1", {24'd0, cnt1}, 32'd0);
      chk("midrst cnt2", {24'd0, cnt2}, 32'd0);

      // 256 items to out0: counter wraps back to zero
      for (int i = 0; i < 256; i++) drive(1'b0, 1'b1, 2'b00, 8'($urandom), 3'b001);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b001);
      #2;
      chk("wrap cnt0", {24'd0, cnt0}, 32'd0);

      // Random traffic, including occasional resets
      for (int i = 0; i < 2000; i++)
         drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
               2'($urandom_range(0, 3)), 8'($urandom), 3'($urandom));
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);
      drive(1'b0, 1'b0, 2'b00, 8'h00, 3'b111);
      @(negedge clk);
      mon_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
